// File: rtl/alu_md.sv
// rtl/alu_md.sv - ALU with iterative unsigned multiply/divide unit and HI/LO registers
// Single-cycle ops are combinational; MULTU/DIVU run WIDTH cycles under a start/busy/done handshake.
module alu_md #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       aluop_i,
   input  logic [WIDTH-1:0] src0_i,
   input  logic [WIDTH-1:0] src1_i,
   output logic [WIDTH-1:0] aluout_o,
   output logic             zero_o,
   output logic             ovf_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_OR    = 4'b0010;
   localparam logic [3:0] OP_AND   = 4'b0011;
   localparam logic [3:0] OP_SLT   = 4'b0100;
   localparam logic [3:0] OP_MULTU = 4'b0101;
   localparam logic [3:0] OP_DIVU  = 4'b0110;
   localparam logic [3:0] OP_MFHI  = 4'b0111;
   localparam logic [3:0] OP_MFLO  = 4'b1000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [CW-1:0]      count;
   logic               is_div;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   operand;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic               busy;
   logic               done;

   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   difference;
   logic               slt;
   logic               launch;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_borrow;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] acc_next;

   assign sum        = src0_i + src1_i;
   assign difference = src0_i - src1_i;
   assign slt        = $signed(src0_i) < $signed(src1_i);

   always_comb begin
      aluout_o = '0;
      ovf_o    = 1'b0;
      case (aluop_i)
         OP_ADD: begin
            aluout_o = sum;
            ovf_o    = (src0_i[WIDTH-1] == src1_i[WIDTH-1]) && (sum[WIDTH-1] != src0_i[WIDTH-1]);
         end
         OP_SUB: begin
            aluout_o = difference;
            ovf_o    = (src0_i[WIDTH-1] != src1_i[WIDTH-1]) && (difference[WIDTH-1] != src0_i[WIDTH-1]);
         end
         OP_OR:   aluout_o = src0_i | src1_i;
         OP_AND:  aluout_o = src0_i & src1_i;
         OP_SLT:  aluout_o = {{(WIDTH-1){1'b0}}, slt};
         OP_MFHI: aluout_o = hi;
         OP_MFLO: aluout_o = lo;
         default: aluout_o = '0;
      endcase
   end

   assign zero_o = (aluout_o == '0);

   // Multiply: acc = {partial product, remaining multiplier}, shifted right each step.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // Divide: acc = {remainder, dividend/quotient}; a zero divisor never borrows,
   // which naturally yields an all-ones quotient and the dividend as remainder.
   assign div_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_borrow = div_shift < {1'b0, operand};
   assign div_diff   = div_shift[WIDTH-1:0] - operand;
   assign div_next   = div_borrow ? {acc[2*WIDTH-2:0], 1'b0}
                                  : {div_diff, acc[WIDTH-2:0], 1'b1};

   assign acc_next = is_div ? div_next : mul_next;

   assign launch = start_i && (state != BUSY) &&
                   ((aluop_i == OP_MULTU) || (aluop_i == OP_DIVU));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         count   <= '0;
         is_div  <= 1'b0;
         acc     <= '0;
         operand <= '0;
         hi      <= '0;
         lo      <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
               if (launch) begin
                  state  <= BUSY;
                  busy   <= 1'b1;
                  count  <= CW'(WIDTH);
                  is_div <= (aluop_i == OP_DIVU);
                  if (aluop_i == OP_DIVU) begin
                     acc     <= {{WIDTH{1'b0}}, src0_i};
                     operand <= src1_i;
                  end else begin
                     acc     <= {{WIDTH{1'b0}}, src1_i};
                     operand <= src0_i;
                  end
               end
            end
            BUSY: begin
               acc <= acc_next;
               if (count == CW'(1)) begin
                  hi    <= acc_next[2*WIDTH-1:WIDTH];
                  lo    <= acc_next[WIDTH-1:0];
                  count <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  count <= count - CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o = busy;
   assign done_o = done;
   assign hi_o   = hi;
   assign lo_o   = lo;

endmodule

// File: tb/tb_alu_md.sv
// tb/tb_alu_md.sv - self-checking bench for alu_md
// Random and directed stimulus against an arithmetic reference model.
module tb_alu_md;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   aluop = 4'd0;
   logic [W-1:0] src0 = '0;
   logic [W-1:0] src1 = '0;
   logic [W-1:0] aluout;
   logic         zero;
   logic         ovf;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int checks = 0;
   int failures = 0;
   logic [W-1:0] model_hi = '0;
   logic [W-1:0] model_lo = '0;

   alu_md #(.WIDTH(W)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .aluop_i(aluop),
      .src0_i(src0), .src1_i(src1), .aluout_o(aluout), .zero_o(zero),
      .ovf_o(ovf), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
   );

   always #5 clk = ~clk;

   // returns {ovf, result}
   function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, s, maxv, minv;
      logic [W-1:0] r;
      logic v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      maxv = (longint'(1) << (W-1)) - 1;
      minv = -(longint'(1) << (W-1));
      r = '0;
      v = 1'b0;
      case (op)
         4'd0: begin s = sa + sb; r = W'(s); v = (s > maxv) || (s < minv); end
         4'd1: begin s = sa - sb; r = W'(s); v = (s > maxv) || (s < minv); end
         4'd2: r = a | b;
         4'd3: r = a & b;
         4'd4: r = (sa < sb) ? W'(1) : W'(0);
         4'd7: r = model_hi;
         4'd8: r = model_lo;
         default: r = '0;
      endcase
      return {v, r};
   endfunction

   task automatic ref_md(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] rh, output logic [W-1:0] rl);
      logic [2*W-1:0] p;
      if (op == 4'd5) begin
         p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
         rh = p[2*W-1:W];
         rl = p[W-1:0];
      end else if (b == '0) begin
         rh = a;
         rl = '1;
      end else begin
         rh = a % b;
         rl = a / b;
      end
   endtask

   task automatic launch(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      aluop = op; src0 = a; src1 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      src0 = $urandom;
      src1 = $urandom;
      aluop = 4'd0;
   endtask

   task automatic wait_busy_low(output int cycles);
      cycles = 0;
      while (busy && cycles < 200) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic test_reset;
      #1 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_flags busy=%b done=%b req 0 0", busy, done); end
      checks++; if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL reset_hilo hi=%h lo=%h req 0 0", hi, lo); end
      aluop = 4'd0; src0 = 32'd3; src1 = 32'd4; #1;
      checks++; if (aluout !== 32'd7) begin failures++; $display("FAIL reset_comb aluout=%h req 7", aluout); end
      aluop = 4'd7; #1;
      checks++; if (aluout !== '0 || zero !== 1'b1) begin failures++; $display("FAIL reset_mfhi aluout=%h zero=%b req 0 1", aluout, zero); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_directed_alu;
      aluop = 4'd0; src0 = 32'h7FFFFFFF; src1 = 32'h1; #1;
      checks++; if (aluout !== 32'h80000000 || ovf !== 1'b1 || zero !== 1'b0) begin failures++; $display("FAIL add_ovf aluout=%h ovf=%b zero=%b req 80000000 1 0", aluout, ovf, zero); end
      aluop = 4'd1; src0 = 32'd5; src1 = 32'd5; #1;
      checks++; if (aluout !== '0 || zero !== 1'b1 || ovf !== 1'b0) begin failures++; $display("FAIL sub_zero aluout=%h zero=%b ovf=%b req 0 1 0", aluout, zero, ovf); end
      aluop = 4'd1; src0 = 32'h80000000; src1 = 32'h1; #1;
      checks++; if (aluout !== 32'h7FFFFFFF || ovf !== 1'b1) begin failures++; $display("FAIL sub_ovf aluout=%h ovf=%b req 7fffffff 1", aluout, ovf); end
      aluop = 4'd4; src0 = 32'hFFFFFFFF; src1 = 32'h1; #1;
      checks++; if (aluout !== 32'd1) begin failures++; $display("FAIL slt_neg aluout=%h req 1", aluout); end
      src0 = 32'h1; src1 = 32'hFFFFFFFF; #1;
      checks++; if (aluout !== 32'd0) begin failures++; $display("FAIL slt_pos aluout=%h req 0", aluout); end
      aluop = 4'd3; src0 = 32'hF0F0; src1 = 32'hFF00; #1;
      checks++; if (aluout !== 32'hF000) begin failures++; $display("FAIL and aluout=%h req f000", aluout); end
   endtask

   task automatic test_random_alu;
      logic [W:0] exp;
      for (int i = 0; i < 60; i++) begin
         aluop = 4'($urandom_range(0, 15));
         src0 = $urandom;
         src1 = (i % 5 == 0) ? src0 : W'($urandom);
         if (i % 7 == 0) src1 = {src0[W-1], 31'($urandom)};
         #1;
         exp = ref_alu(aluop, src0, src1);
         checks++;
         if (aluout !== exp[W-1:0] || ovf !== exp[W] || zero !== (exp[W-1:0] == '0)) begin
            failures++;
            $display("FAIL rand_alu op=%0d a=%h b=%h aluout=%h ovf=%b zero=%b req %h %b %b",
                     aluop, src0, src1, aluout, ovf, zero, exp[W-1:0], exp[W], exp[W-1:0] == '0);
         end
      end
   endtask

   task automatic test_ignored_nonmd;
      @(negedge clk); aluop = 4'd0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nonmd_start busy=%b req 0", busy); end
   endtask

   task automatic test_multu;
      int cycles;
      launch(4'd5, 32'hFFFFFFFF, 32'd2);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mul_busy_rise busy=%b req 1", busy); end
      wait_busy_low(cycles);
      checks++; if (cycles !== 32) begin failures++; $display("FAIL mul_busy_len cycles=%0d req 32", cycles); end
      checks++; if (done !== 1'b1 || hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL mul_result done=%b hi=%h lo=%h req 1 1 fffffffe", done, hi, lo); end
      model_hi = 32'h1; model_lo = 32'hFFFFFFFE;
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mul_done_fall done=%b busy=%b req 0 0", done, busy); end
      aluop = 4'd8; #1;
      checks++; if (aluout !== 32'hFFFFFFFE) begin failures++; $display("FAIL mflo aluout=%h req fffffffe", aluout); end
   endtask

   task automatic test_divu;
      int cycles;
      launch(4'd6, 32'd100, 32'd7);
      wait_busy_low(cycles);
      checks++; if (cycles !== 32 || done !== 1'b1 || lo !== 32'd14 || hi !== 32'd2) begin failures++; $display("FAIL div_basic cycles=%0d done=%b lo=%h hi=%h req 32 1 e 2", cycles, done, lo, hi); end
      launch(4'd6, 32'h1234, 32'd0);
      wait_busy_low(cycles);
      checks++; if (cycles !== 32 || lo !== 32'hFFFFFFFF || hi !== 32'h1234) begin failures++; $display("FAIL div_zero cycles=%0d lo=%h hi=%h req 32 ffffffff 1234", cycles, lo, hi); end
      model_hi = 32'h1234; model_lo = 32'hFFFFFFFF;
   endtask

   task automatic test_ignore_start;
      int cycles, c2;
      logic [W-1:0] a, b, eh, el;
      a = $urandom; b = $urandom;
      ref_md(4'd5, a, b, eh, el);
      launch(4'd5, a, b);
      cycles = 0;
      repeat (9) begin @(posedge clk); #1; cycles++; end
      aluop = 4'd6; src0 = $urandom; src1 = 32'd3; start = 1'b1;
      @(posedge clk); #1; cycles++;
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy busy=%b req 1", busy); end
      aluop = 4'd7; #1;
      checks++; if (aluout !== model_hi) begin failures++; $display("FAIL mfhi_busy aluout=%h req %h", aluout, model_hi); end
      wait_busy_low(c2);
      cycles += c2;
      checks++; if (cycles !== 32 || hi !== eh || lo !== el) begin failures++; $display("FAIL ignore_result cycles=%0d hi=%h lo=%h req 32 %h %h", cycles, hi, lo, eh, el); end
      model_hi = eh; model_lo = el;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL ignore_no_requeue busy=%b done=%b req 0 0", busy, done); end
   endtask

   task automatic test_back_to_back;
      int cycles;
      logic [W-1:0] a, b, eh, el;
      launch(4'd6, 32'd1000, 32'd33);
      wait_busy_low(cycles);
      checks++; if (done !== 1'b1 || lo !== 32'd30 || hi !== 32'd10) begin failures++; $display("FAIL b2b_first done=%b lo=%h hi=%h req 1 1e a", done, lo, hi); end
      a = $urandom; b = $urandom;
      ref_md(4'd5, a, b, eh, el);
      aluop = 4'd5; src0 = a; src1 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; src0 = $urandom; src1 = $urandom;
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_nogap busy=%b done=%b req 1 0", busy, done); end
      wait_busy_low(cycles);
      checks++; if (cycles !== 32 || done !== 1'b1 || hi !== eh || lo !== el) begin failures++; $display("FAIL b2b_second cycles=%0d hi=%h lo=%h req 32 %h %h", cycles, hi, lo, eh, el); end
      model_hi = eh; model_lo = el;
   endtask

   task automatic test_random_md;
      int cycles;
      logic [3:0] op;
      logic [W-1:0] a, b, eh, el;
      for (int i = 0; i < 6; i++) begin
         op = (i % 2 == 0) ? 4'd5 : 4'd6;
         a = $urandom;
         b = (i == 3) ? W'(0) : ((i == 5) ? W'($urandom_range(1, 255)) : W'($urandom));
         ref_md(op, a, b, eh, el);
         launch(op, a, b);
         wait_busy_low(cycles);
         checks++;
         if (cycles !== 32 || done !== 1'b1 || hi !== eh || lo !== el) begin
            failures++;
            $display("FAIL rand_md op=%0d a=%h b=%h cycles=%0d hi=%h lo=%h req 32 %h %h", op, a, b, cycles, hi, lo, eh, el);
         end
         model_hi = eh; model_lo = el;
      end
   endtask

   task automatic test_reset_mid;
      bit seen_done;
      launch(4'd6, $urandom, 32'd9);
      repeat (15) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin failures++; $display("FAIL rst_mid busy=%b hi=%h lo=%h req 0 0 0", busy, hi, lo); end
      model_hi = '0; model_lo = '0;
      @(negedge clk); rst = 1'b0;
      seen_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      checks++; if (seen_done !== 1'b0 || busy !== 1'b0 || hi !== '0 || lo !== '0) begin failures++; $display("FAIL rst_no_done done_seen=%b busy=%b hi=%h lo=%h req 0 0 0 0", seen_done, busy, hi, lo); end
   endtask

   initial begin
      test_reset();
      test_directed_alu();
      test_random_alu();
      test_ignored_nonmd();
      test_multu();
      test_divu();
      test_ignore_start();
      test_back_to_back();
      test_random_md();
      test_random_alu();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_md.md
# alu_md

Parametrised successor to the datapath ALU. It adds AND, signed SLT, signed-overflow detection and an iterative unsigned multiply/divide unit with architectural HI/LO registers. Single-cycle ops stay combinational. MULTU/DIVU run as a multi-cycle sequencer with a start/busy/done handshake that the control unit uses to stall the pipeline-free datapath.

## Interface
- WIDTH, 32: operand, result, HI and LO width (≥4, even).
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  launch request; acted on only with aluop_i = MULTU/DIVU and busy_o = 0.
- aluop_i  in  4  operation select (encoding below).
- src0_i  in  WIDTH  operand A / multiplicand / dividend.
- src1_i  in  WIDTH  operand B / multiplier / divisor.
- aluout_o  out  WIDTH  combinational result.
- zero_o  out  1  aluout_o == 0.
- ovf_o  out  1  signed overflow for ADD/SUB; 0 otherwise.
- busy_o  out  1  multiply/divide in progress.
- done_o  out  1  one-cycle pulse; HI/LO hold the new result.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

## Operation
- aluop_i encoding:
  - 0000 ADD: A+B mod 2^WIDTH.
  - 0001 SUB: A−B.
  - 0010 OR.
  - 0011 AND.
  - 0100 SLT: signed A<B gives 1, else 0.
  - 0101 MULTU and 0110 DIVU: aluout_o = 0.
  - 0111 MFHI: hi_o.
  - 1000 MFLO: lo_o.
  - All other codes: aluout_o = 0.
- aluout_o, zero_o and ovf_o are purely combinational from the current inputs and HI/LO. No latches; every output is assigned for every opcode.
- ovf_o:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from A.
- The MD sequencer has three states:
  - IDLE→BUSY: on start_i with opcode MULTU/DIVU. Operands, op type and counter (=WIDTH) are latched.
  - BUSY: one iteration per cycle; counter decrements; at count 1 the next edge writes HI/LO and goes to DONE.
  - DONE→IDLE: the next cycle. A valid start_i in DONE goes directly to BUSY instead.
- MULTU: shift-add over a 2·WIDTH accumulator. Result HI = upper WIDTH bits, LO = lower WIDTH bits.
- DIVU: restoring, one quotient bit per cycle. LO = quotient, HI = remainder.
- Divide by zero runs the full WIDTH cycles and yields LO = all ones and HI = dividend. No trap is raised.
- Ignored launch requests:
  - start_i while BUSY: ignored; the operation in flight is unaffected.
  - start_i with a non-MD opcode: ignored.
- HI/LO change only at the completing edge. MFHI/MFLO during BUSY return the previous values.

## Timing
- Reset (async assert, immediate):
  - State is IDLE.
  - hi_o = lo_o = 0, busy_o = 0, done_o = 0, counter = 0.
  - Combinational outputs follow the inputs (with HI/LO = 0).
- Reset mid-operation aborts the operation; no HI/LO update; no done_o.
- Launch and completion: with start sampled at edge E0:
  - busy_o is high from E0 until E_WIDTH, i.e. for WIDTH cycles.
  - At E_WIDTH, HI/LO are written, busy_o falls and done_o rises.
  - done_o falls at E_WIDTH+1.
- Result latency is WIDTH cycles start-to-HI/LO. A back-to-back issue is possible every WIDTH+1 cycles.
- Operand changes after E0 do not affect the result.
- Single-cycle ops: zero latency, valid the same cycle, usable while BUSY.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → aluout 0x80000000, ovf_o = 1, zero_o = 0. SUB 5−5 → aluout 0, zero_o = 1, ovf_o = 0.
- SLT A = 0xFFFFFFFF, B = 1 → 1; SLT A = 1, B = 0xFFFFFFFF → 0; AND 0xF0F0 & 0xFF00 → 0xF000.
- MULTU 0xFFFFFFFF × 2 with start pulse → busy_o high for exactly 32 cycles, then done_o for 1 cycle with hi = 0x1, lo = 0xFFFFFFFE. MFLO afterwards → 0xFFFFFFFE.
- DIVU 100 / 7 → lo = 14, hi = 2. DIVU 0x1234 / 0 → lo = 0xFFFFFFFF, hi = 0x1234 after 32 cycles.
- start_i with DIVU asserted at cycle 10 of a MULTU → ignored; the MULTU result is unchanged. MFHI during BUSY returns the old HI. Start in the DONE cycle → new op accepted with no IDLE gap.
- rst_i asserted mid-DIVU (cycle 15) → busy_o = 0, hi = lo = 0 immediately; no done_o pulse after release.
